// File: rtl/alu_serial_if.sv
// Handshake and operand/result bundle for the slice-serial ALU.
interface alu_serial_if #(
    parameter int WIDTH = 64
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [1:0]       op;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             zero;
    logic             ovf;

    // Requester side: issues operations and observes results.
    modport master (
        output start, a, b, cin, op,
        input  busy, done, s, cout, zero, ovf
    );

    // ALU side: accepts operations and produces results.
    modport slave (
        input  start, a, b, cin, op,
        output busy, done, s, cout, zero, ovf
    );
endinterface

// File: rtl/alu_serial.sv
// Slice-serial ALU: NOR/XOR/ADD/SUB on WIDTH-bit operands, SLICE bits per
// clock, LSB slice first, with a carry register bridging the slices.
module alu_serial #(
    parameter int WIDTH = 64,
    parameter int SLICE = 8
) (
    input logic         clk,
    input logic         rst,
    alu_serial_if.slave bus
);
    localparam int N  = WIDTH / SLICE;
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_reg, state_next;
    logic [KW-1:0]    k_reg;
    logic [WIDTH-1:0] a_reg, b_reg, s_reg;
    logic [1:0]       op_reg;
    logic             carry_reg, cout_reg, zero_reg, ovf_reg;

    logic             accept, last;
    logic [SLICE-1:0] a_sl, b_sl, bp_sl, logic_sl, res_sl;
    logic [SLICE:0]   sum_sl;
    logic             slice_cout, bp_msb, ovf_final;
    logic [WIDTH-1:0] s_merged;

    // New work is taken only when nothing is in flight.
    assign accept = bus.start && (state_reg == IDLE || state_reg == DONE);
    assign last   = (k_reg == KW'(N - 1));

    assign a_sl = a_reg[k_reg*SLICE +: SLICE];
    assign b_sl = b_reg[k_reg*SLICE +: SLICE];

    // Per-bit operand conditioning and logic result; op[0] selects
    // inverted B for SUB and XOR (vs NOR) for the logic pair.
    generate
        for (genvar gi = 0; gi < SLICE; gi++) begin : g_bit
            assign bp_sl[gi]    = op_reg[0] ? ~b_sl[gi] : b_sl[gi];
            assign logic_sl[gi] = op_reg[0] ? (a_sl[gi] ^ b_sl[gi])
                                            : ~(a_sl[gi] | b_sl[gi]);
        end
    endgenerate

    assign sum_sl     = {1'b0, a_sl} + {1'b0, bp_sl} + {{SLICE{1'b0}}, carry_reg};
    assign res_sl     = op_reg[1] ? sum_sl[SLICE-1:0] : logic_sl;
    assign slice_cout = op_reg[1] & sum_sl[SLICE];

    // Overflow uses the final slice's MSB, which is the result MSB.
    assign bp_msb    = op_reg[0] ? ~b_reg[WIDTH-1] : b_reg[WIDTH-1];
    assign ovf_final = op_reg[1] & (a_reg[WIDTH-1] ~^ bp_msb)
                                 & (res_sl[SLICE-1] ^ a_reg[WIDTH-1]);

    // Result with the current slice merged in, so zero sees the full word.
    always_comb begin
        s_merged = s_reg;
        s_merged[k_reg*SLICE +: SLICE] = res_sl;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_next = state_reg;
        bus.busy   = 1'b0;
        bus.done   = 1'b0;
        case (state_reg)
            IDLE: if (bus.start) state_next = RUN;
            RUN: begin
                bus.busy = 1'b1;
                if (last) state_next = DONE;
            end
            DONE: begin
                bus.done   = 1'b1;
                state_next = bus.start ? RUN : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand latch, slice counter, carry chain and result/flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            k_reg     <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            op_reg    <= 2'b00;
            carry_reg <= 1'b0;
            s_reg     <= '0;
            cout_reg  <= 1'b0;
            zero_reg  <= 1'b1;
            ovf_reg   <= 1'b0;
        end else if (accept) begin
            k_reg     <= '0;
            a_reg     <= bus.a;
            b_reg     <= bus.b;
            op_reg    <= bus.op;
            carry_reg <= bus.op[1] & bus.cin;
        end else if (state_reg == RUN) begin
            s_reg     <= s_merged;
            carry_reg <= slice_cout;
            k_reg     <= last ? '0 : k_reg + 1'b1;
            if (last) begin
                cout_reg <= slice_cout;
                zero_reg <= (s_merged == '0);
                ovf_reg  <= ovf_final;
            end
        end
    end

    assign bus.s    = s_reg;
    assign bus.cout = cout_reg;
    assign bus.zero = zero_reg;
    assign bus.ovf  = ovf_reg;
endmodule
